// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle RV32I core: holds the PC and
// selects the next fetch address, with stall, halt/resume, boot and trapping.
module pc_sequencer #(
  parameter int                 ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'('h3F0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jalr_en,
  input  logic [ADDR_W-1:0] jalr_base,
  input  logic [ADDR_W-1:0] jalr_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] exc_pc,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;
  logic              exc_q, exc_d;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  // JALR clears bit 0 of the sum; the carry out of ADDR_W is dropped.
  function automatic logic [ADDR_W-1:0] jalr_target(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] offs
  );
    logic [ADDR_W-1:0] sum;
    sum    = base + offs;
    sum[0] = 1'b0;
    return sum;
  endfunction

  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    exc_d    = 1'b0;
    exc_pc_d = exc_pc_q;
    redirect = jalr_en | br_taken;
    target   = pc_plus4;
    if (jalr_en)
      target = jalr_target(jalr_base, jalr_offset);
    else if (br_taken)
      target = pc_q + br_offset;

    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          // A misaligned redirect wins over halt_req; pc+4 cannot misalign.
          if (redirect && target[1]) begin
            pc_d     = TRAP_VEC;
            exc_pc_d = target;
            exc_d    = 1'b1;
            state_d  = S_TRAP;
          end else begin
            pc_d    = target;
            state_d = halt_req ? S_HALT : S_RUN;
          end
        end
      end
      S_HALT: if (resume) state_d = S_RUN;
      S_TRAP: state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_VEC;
      exc_q    <= 1'b0;
      exc_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      exc_q    <= exc_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = (state_q == S_RUN);
  assign misalign_exc = exc_q;
  assign exc_pc       = exc_pc_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the main scenarios plus random
// stimulus, all checked each cycle against an arithmetic model of the PC rules.
module tb_pc_sequencer;
  localparam int ADDR_W = 10;
  localparam int MODV   = 1 << ADDR_W;
  localparam int RVEC   = 0;
  localparam int TVEC   = 'h3F0;

  logic              clk = 1'b0;
  logic              rst, stall, halt_req, resume, br_taken, jalr_en;
  logic [ADDR_W-1:0] br_offset, jalr_base, jalr_offset;
  logic [ADDR_W-1:0] pc, pc_plus4, exc_pc;
  logic              pc_valid, misalign_exc;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;

  // Reference state: 0=BOOT 1=RUN 2=HALT 3=TRAP
  int m_pc, m_st, m_exc, m_excpc;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .br_taken(br_taken), .br_offset(br_offset), .jalr_en(jalr_en),
    .jalr_base(jalr_base), .jalr_offset(jalr_offset), .pc(pc),
    .pc_plus4(pc_plus4), .pc_valid(pc_valid), .misalign_exc(misalign_exc),
    .exc_pc(exc_pc), .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    br_taken = 1'b0; jalr_en = 1'b0;
    br_offset = '0; jalr_base = '0; jalr_offset = '0;
  endtask

  // Advance the reference by one clock using the currently driven inputs.
  task automatic model_step();
    int tgt;
    if (rst) begin
      m_pc = RVEC; m_st = 0; m_exc = 0; m_excpc = 0;
    end else begin
      m_exc = 0;
      case (m_st)
        0: m_st = 1;
        1: if (!stall) begin
          if (jalr_en) begin
            tgt = (int'(jalr_base) + int'(jalr_offset)) % MODV;
            tgt = tgt - (tgt % 2);
          end else if (br_taken)
            tgt = (m_pc + int'(br_offset)) % MODV;
          else
            tgt = (m_pc + 4) % MODV;
          if ((jalr_en || br_taken) && (tgt % 4) >= 2) begin
            m_excpc = tgt; m_pc = TVEC; m_exc = 1; m_st = 3;
          end else begin
            m_pc = tgt;
            m_st = halt_req ? 2 : 1;
          end
        end
        2: if (resume) m_st = 1;
        default: m_st = 1;
      endcase
    end
  endtask

  task automatic compare();
    chk("state", 32'(state), 32'(m_st));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_plus4", 32'(pc_plus4), 32'((m_pc + 4) % MODV));
    chk("pc_valid", 32'(pc_valid), (m_st == 1) ? 32'd1 : 32'd0);
    chk("misalign_exc", 32'(misalign_exc), 32'(m_exc));
    chk("exc_pc", 32'(exc_pc), 32'(m_excpc));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic go_to(input int addr);
    idle(); jalr_en = 1'b1; jalr_base = ADDR_W'(addr); cyc(); idle();
  endtask

  initial begin
    int r;
    idle();
    m_pc = 0; m_st = 0; m_exc = 0; m_excpc = 0;

    // 1. reset and sequential run
    rst = 1'b1; cyc(); cyc();
    chk("boot_state", 32'(state), 32'd0);
    chk("boot_pc", 32'(pc), 32'h0);
    chk("boot_valid", 32'(pc_valid), 32'd0);
    idle(); cyc();
    chk("run0_pc", 32'(pc), 32'h0);
    chk("run0_valid", 32'(pc_valid), 32'd1);
    chk("run0_plus4", 32'(pc_plus4), 32'h4);
    cyc(); chk("run1_pc", 32'(pc), 32'h4);
    cyc(); chk("run2_pc", 32'(pc), 32'h8);

    // 2. branch, wrap, jalr, jalr+branch
    br_taken = 1'b1; br_offset = 'h010; cyc(); idle();
    chk("branch_pc", 32'(pc), 32'h018);
    cyc(); chk("seq_c_pc", 32'(pc), 32'h01C);
    go_to('h3FC);
    chk("pre_wrap_plus4", 32'(pc_plus4), 32'h000);
    cyc(); chk("wrap_pc", 32'(pc), 32'h000);
    jalr_en = 1'b1; jalr_base = 'h101; jalr_offset = 'h003; cyc(); idle();
    chk("jalr_pc", 32'(pc), 32'h104);
    jalr_en = 1'b1; jalr_base = 'h020; br_taken = 1'b1; br_offset = 'h100; cyc(); idle();
    chk("jalr_wins_pc", 32'(pc), 32'h020);

    // 3. misaligned trap, then again with halt_req
    br_taken = 1'b1; br_offset = 'h002; cyc(); idle();
    chk("trap_state", 32'(state), 32'd3);
    chk("trap_pc", 32'(pc), 32'h3F0);
    chk("trap_exc", 32'(misalign_exc), 32'd1);
    chk("trap_excpc", 32'(exc_pc), 32'h022);
    chk("trap_valid", 32'(pc_valid), 32'd0);
    cyc();
    chk("post_trap_state", 32'(state), 32'd1);
    chk("post_trap_pc", 32'(pc), 32'h3F0);
    chk("post_trap_exc", 32'(misalign_exc), 32'd0);
    go_to('h020);
    br_taken = 1'b1; br_offset = 'h002; halt_req = 1'b1; cyc(); idle();
    chk("trap_halt_state", 32'(state), 32'd3);
    cyc(); chk("trap_halt_run", 32'(state), 32'd1);

    // 4. stall with stray branch pulses
    go_to('h040);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; br_taken = (i % 2 == 0); br_offset = 'h100; cyc();
      chk("stall_pc", 32'(pc), 32'h040);
      chk("stall_valid", 32'(pc_valid), 32'd1);
    end
    idle(); cyc(); chk("unstall_pc", 32'(pc), 32'h044);

    // 5. halt / resume
    go_to('h050);
    halt_req = 1'b1; cyc(); idle();
    chk("halt_state", 32'(state), 32'd2);
    chk("halt_pc", 32'(pc), 32'h054);
    chk("halt_valid", 32'(pc_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      br_taken = 1'b1; br_offset = 'h080; cyc();
      chk("halt_hold_pc", 32'(pc), 32'h054);
    end
    idle(); resume = 1'b1; cyc(); idle();
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_pc", 32'(pc), 32'h054);
    cyc(); chk("resume_next_pc", 32'(pc), 32'h058);

    // 6. reset during HALT and during TRAP
    halt_req = 1'b1; cyc(); idle();
    rst = 1'b1; cyc(); idle();
    chk("rst_halt_state", 32'(state), 32'd0);
    chk("rst_halt_pc", 32'(pc), 32'h0);
    cyc();
    br_taken = 1'b1; br_offset = 'h002; cyc(); idle();
    chk("pre_rst_trap_excpc", 32'(exc_pc), 32'h002);
    rst = 1'b1; cyc(); idle();
    chk("rst_trap_state", 32'(state), 32'd0);
    chk("rst_trap_exc", 32'(misalign_exc), 32'd0);
    chk("rst_trap_excpc", 32'(exc_pc), 32'h0);
    chk("rst_trap_pc", 32'(pc), 32'h0);

    // Random stimulus against the model
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst       = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 20);
      halt_req  = ($urandom_range(0, 99) < 8);
      resume    = ($urandom_range(0, 99) < 30);
      br_taken  = ($urandom_range(0, 99) < 30);
      jalr_en   = ($urandom_range(0, 99) < 15);
      r         = $urandom_range(0, 255) * 4 + (($urandom_range(0, 99) < 15) ? 2 : 0);
      br_offset = ADDR_W'(r);
      jalr_base = ADDR_W'($urandom_range(0, 255) * 4);
      r         = $urandom_range(0, 255) * 4 + (($urandom_range(0, 99) < 25) ? $urandom_range(1, 3) : 0);
      jalr_offset = ADDR_W'(r);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
